// File: rtl/dispatch.sv
//============================================================================
// Module   : dispatch
// Brief    : 1-to-4 write demultiplexer with per-channel occupancy,
//            consumer acknowledge, drop detection and accepted-write counter.
// Revision : 1.0
//============================================================================
`default_nettype none

module dispatch #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D,
    input  logic [1:0]       addr,
    input  logic             N,
    input  logic [3:0]       ack,
    output logic             Y0,
    output logic             Y1,
    output logic             Y2,
    output logic             Y3,
    output logic [3:0]       full,
    output logic             err,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      st_q [4];
    chan_state_t      st_d [4];
    logic [3:0]       y_q, y_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i] <= EMPTY;
            end
            y_q   <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i] <= st_d[i];
            end
            y_q   <= y_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    // An ack on the addressed channel frees the slot for the incoming write
    // in the same edge, so an occupied channel can be refilled without a gap.
    always_comb begin
        y_d    = y_q;
        accept = 1'b0;
        err_d  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_d[i] = st_q[i];
        end

        for (int i = 0; i < 4; i++) begin
            if (N && (addr == 2'(i))) begin
                if ((st_q[i] == EMPTY) || ack[i]) begin
                    y_d[i]  = D;
                    st_d[i] = FULL;
                    accept  = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
            end else if (ack[i] && (st_q[i] == FULL)) begin
                st_d[i] = EMPTY;
            end
        end

        cnt_d = cnt_q + CNT_W'(accept);
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i] = (st_q[i] == FULL);
        end
    end

    assign Y0  = y_q[0];
    assign Y1  = y_q[1];
    assign Y2  = y_q[2];
    assign Y3  = y_q[3];
    assign err = err_q;
    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dispatch.sv
//============================================================================
// Module   : tb_dispatch
// Brief    : Randomized self-checking bench for dispatch against a
//            behavioural occupancy/counter model.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_dispatch;

    localparam int CNT_W = 8;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             D     = 1'b0;
    logic [1:0]       addr  = 2'd0;
    logic             N     = 1'b0;
    logic [3:0]       ack   = 4'd0;
    logic             Y0, Y1, Y2, Y3;
    logic [3:0]       full;
    logic             err;
    logic [CNT_W-1:0] cnt;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [3:0] m_full = 4'd0;
    logic [3:0] m_y    = 4'd0;
    logic       m_err  = 1'b0;
    int         m_cnt  = 0;

    dispatch #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .D    (D),
        .addr (addr),
        .N    (N),
        .ack  (ack),
        .Y0   (Y0),
        .Y1   (Y1),
        .Y2   (Y2),
        .Y3   (Y3),
        .full (full),
        .err  (err),
        .cnt  (cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_full = 4'd0;
            m_y    = 4'd0;
            m_err  = 1'b0;
            m_cnt  = 0;
        end else begin
            bit acc;
            acc   = N && (!m_full[addr] || ack[addr]);
            m_err = N && !acc;
            for (int i = 0; i < 4; i++) begin
                if (ack[i] && !(N && addr == 2'(i))) m_full[i] = 1'b0;
            end
            if (acc) begin
                m_y[addr]    = D;
                m_full[addr] = 1'b1;
                m_cnt        = (m_cnt + 1) % (1 << CNT_W);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: DUT against model every cycle, mid-period.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_full", int'(full), int'(m_full));
            chk("model_y",    int'({Y3, Y2, Y1, Y0}), int'(m_y));
            chk("model_err",  int'(err), int'(m_err));
            chk("model_cnt",  int'(cnt), m_cnt);
        end
    end

    task automatic drive(input bit n, input int a, input bit d, input logic [3:0] k);
        N    = n;
        addr = 2'(a);
        D    = d;
        ack  = k;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        N     = 1'b0;
        ack   = 4'd0;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset    = 1'b0;
        check_en = 1'b1;
        chk("reset_full", int'(full), 0);
        chk("reset_cnt",  int'(cnt), 0);
        chk("reset_err",  int'(err), 0);

        // Single write to channel 2
        drive(1, 2, 1, 4'd0);
        N = 1'b0;
        chk("w2_y2",   int'(Y2), 1);
        chk("w2_full", int'(full), 4);
        chk("w2_cnt",  int'(cnt), 1);
        chk("w2_err",  int'(err), 0);
        chk("w2_oth",  int'({Y3, Y1, Y0}), 0);

        // Fill all channels, then free channel 0
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, i, 1, 4'd0);
        chk("fill_full", int'(full), 15);
        chk("fill_cnt",  int'(cnt), 4);
        drive(0, 0, 0, 4'b0001);
        chk("ack0_full", int'(full), 14);
        chk("ack0_y0",   int'(Y0), 1);

        // Drop on occupied channel 1
        drive(1, 1, 0, 4'd0);
        chk("drop_y1",  int'(Y1), 1);
        chk("drop_cnt", int'(cnt), 4);
        chk("drop_err", int'(err), 1);
        drive(0, 0, 0, 4'd0);
        chk("drop_err_clr", int'(err), 0);

        // Back-to-back drops hold err
        drive(1, 2, 0, 4'd0);
        drive(1, 2, 0, 4'd0);
        chk("drop2_err", int'(err), 1);

        // Refill channel 3 with simultaneous ack
        drive(1, 3, 0, 4'b1000);
        chk("refill_y3",   int'(Y3), 0);
        chk("refill_full", int'(full[3]), 1);
        chk("refill_cnt",  int'(cnt), 5);
        chk("refill_err",  int'(err), 0);
        drive(0, 0, 0, 4'd0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            logic [3:0] k;
            for (int b = 0; b < 4; b++) k[b] = ($urandom_range(0, 3) == 0);
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)), k);
        end

        // Counter wrap through 256 refills of channel 0
        do_reset();
        for (int c = 0; c < 256; c++) drive(1, 0, bit'($urandom_range(0, 1)), 4'b0001);
        N = 1'b0;
        chk("wrap_cnt", int'(cnt), 0);
        chk("wrap_err", int'(err), 0);

        // Asynchronous reset between edges with full=1011
        do_reset();
        drive(1, 0, 1, 4'd0);
        drive(1, 1, 1, 4'd0);
        drive(1, 3, 1, 4'd0);
        N = 1'b0;
        chk("pre_ar_full", int'(full), 11);
        #1 reset = 1'b1;
        #1;
        chk("ar_full", int'(full), 0);
        chk("ar_cnt",  int'(cnt), 0);
        chk("ar_y",    int'({Y3, Y2, Y1, Y0}), 0);
        N    = 1'b1;
        addr = 2'd2;
        D    = 1'b1;
        @(posedge clk);
        #2;
        chk("ar_ignored", int'(full), 0);
        reset = 1'b0;
        drive(1, 1, 1, 4'd0);
        N = 1'b0;
        chk("post_ar_y1",   int'(Y1), 1);
        chk("post_ar_full", int'(full), 2);
        chk("post_ar_cnt",  int'(cnt), 1);

        @(posedge clk);
        #2;
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dispatch.md
DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 Parameter: CNT_W, 8, width of the accepted-write counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: D  input  1  data bit to be routed.
REQ-005 Port: addr  input  2  destination channel select (0..3).
REQ-006 Port: N  input  1  write strobe, active-high; D/addr sampled only when N=1.
REQ-007 Port: ack  input  4  per-channel consumer acknowledge, bit i frees channel i.
REQ-008 Port: Y0, Y1, Y2, Y3  output  1 each  registered channel data.
REQ-009 Port: full  output  4  bit i = 1 while channel i holds unconsumed data.
REQ-010 Port: err  output  1  one-cycle pulse: write dropped on an occupied channel.
REQ-011 Port: cnt  output  CNT_W  count of accepted writes.

Function
REQ-012 The block SHALL act as the 1-to-4 demultiplexer counterpart of a 4-to-1 select: D is steered to the channel selected by addr.
REQ-013 Write accept: at a clock edge with N=1 and full[addr]=0, the block SHALL load Y[addr]<=D and set full[addr]<=1; visible the next cycle (1-cycle latency).
REQ-014 Accepted write SHALL increment cnt by 1; cnt wraps from 2^CNT_W-1 to 0 with no flag.
REQ-015 Non-addressed channels SHALL hold Y and full unchanged on any write.
REQ-016 Ack: at an edge with ack[i]=1, full[i]=1 and no write to channel i, full[i]<=0; Y[i] SHALL hold its last value.
REQ-017 Ack to an empty channel (full[i]=0) SHALL be ignored; no state change.
REQ-018 Simultaneous write and ack to the same occupied channel: write SHALL be accepted (Y updated, full stays 1, cnt+1, err=0).
REQ-019 Simultaneous write and ack to the same empty channel: write accepted, ack ignored, full[addr]<=1.
REQ-020 Drop: at an edge with N=1, full[addr]=1 and ack[addr]=0, the write SHALL be discarded (Y, full, cnt unchanged) and err=1 for exactly the following cycle.
REQ-021 err SHALL be 0 in every cycle not immediately following a drop; back-to-back drops hold err=1 continuously.
REQ-022 Acks to other channels in the same cycle as a write SHALL be processed independently per REQ-016/017.
REQ-023 Per-channel state machine: EMPTY (full=0) -> FULL on accepted write; FULL -> EMPTY on ack without write; FULL -> FULL on write+ack (refill) or on drop; EMPTY -> EMPTY on ack or idle.
REQ-024 With N=0, D and addr SHALL have no effect.
REQ-025 No combinational path from any input to any output; all outputs registered.

Reset
REQ-026 On reset=1, immediately and independent of clk: Y0..Y3=0, full=4'b0000, err=0, cnt=0.
REQ-027 While reset=1 all writes and acks SHALL be ignored; operation resumes at the first rising edge after reset deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all held data and any pending err pulse.

Verification
REQ-029 Reset, then N=1, addr=2, D=1 for one cycle -> next cycle Y2=1, full=4'b0100, cnt=1, err=0; Y0/Y1/Y3=0.
REQ-030 Fill all: writes D=1 to addr 0,1,2,3 on consecutive cycles -> full=4'b1111, cnt=4; then ack=4'b0001 -> full=4'b1110, Y0 stays 1.
REQ-031 Drop: channel 1 full, N=1, addr=1, D=0, ack=0 -> Y1 stays 1, cnt unchanged, err=1 for one cycle then 0.
REQ-032 Refill: channel 3 full with Y3=1, N=1, addr=3, D=0, ack=4'b1000 -> Y3=0, full[3]=1, cnt+1, err=0.
REQ-033 Wrap: 256 accept/ack cycles on channel 0 with CNT_W=8 -> cnt returns to 0, no err.
REQ-034 Async reset: assert reset between clock edges with full=4'b1011 -> outputs clear before next edge; write in first cycle after release accepted normally.
